// File: rtl/in_order_writeback_pkg.sv
// Shared UArch package for the in-order writeback block: ROB depth helper and
// commit trace formatting constants/helpers.
package in_order_writeback_pkg;

    // Trace layout is "H:hh A:hh R:hh"; sequence numbers print as two hex digits.
    localparam int          TRACE_CHARS = 14;
    localparam logic [15:0] TRACE_IDLE  = "--";

    function automatic int rob_depth(input int seq_bits);
        return 1 << seq_bits;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

    function automatic logic [15:0] hex_byte(input logic [7:0] v);
        return {hex_char(v[7:4]), hex_char(v[3:0])};
    endfunction

endpackage

// File: rtl/in_order_writeback_if.sv
// Execute-to-writeback message channel (val/rdy handshake with sequence number).
interface X__WIntf #(
    parameter int p_addr_bits    = 32,
    parameter int p_data_bits    = 32,
    parameter int p_seq_num_bits = 5
);
    logic                      val;
    logic                      rdy;
    logic [p_addr_bits-1:0]    pc;
    logic [p_seq_num_bits-1:0] seq_num;
    logic [4:0]                waddr;
    logic [p_data_bits-1:0]    wdata;
    logic                      wen;

    modport send (output val, pc, seq_num, waddr, wdata, wen, input rdy);
    modport recv (input val, pc, seq_num, waddr, wdata, wen, output rdy);
endinterface

// File: rtl/wb_rob_storage.sv
// Reorder-buffer payload array indexed by seq_num: one write port, one
// combinational read port (driven with the head pointer).
module wb_rob_storage
    import in_order_writeback_pkg::*;
#(
    parameter int p_addr_bits    = 32,
    parameter int p_data_bits    = 32,
    parameter int p_seq_num_bits = 5
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [p_seq_num_bits-1:0] wr_idx,
    input  logic [p_addr_bits-1:0]    wr_pc,
    input  logic [4:0]                wr_waddr,
    input  logic [p_data_bits-1:0]    wr_wdata,
    input  logic                      wr_wen,
    input  logic [p_seq_num_bits-1:0] rd_idx,
    output logic [p_addr_bits-1:0]    rd_pc,
    output logic [4:0]                rd_waddr,
    output logic [p_data_bits-1:0]    rd_wdata,
    output logic                      rd_wen
);
    localparam int DEPTH = rob_depth(p_seq_num_bits);

    typedef struct packed {
        logic [p_addr_bits-1:0] pc;
        logic [4:0]             waddr;
        logic [p_data_bits-1:0] wdata;
        logic                   wen;
    } entry_t;

    entry_t mem [DEPTH];

    // NOTE: payload is deliberately not reset; the valid bits in the parent
    // decide whether an entry is meaningful, so a reset here only costs area.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= '{pc: wr_pc, waddr: wr_waddr, wdata: wr_wdata, wen: wr_wen};
    end

    assign rd_pc    = mem[rd_idx].pc;
    assign rd_waddr = mem[rd_idx].waddr;
    assign rd_wdata = mem[rd_idx].wdata;
    assign rd_wen   = mem[rd_idx].wen;
endmodule

// File: rtl/in_order_writeback.sv
// In-order writeback: buffers out-of-order execute results by seq_num and retires
// them one per cycle in order. `IN_ORDER_WRITEBACK_BYPASS_EN adds a 0-latency head bypass.
module in_order_writeback
    import in_order_writeback_pkg::*;
#(
    parameter int p_addr_bits    = 32,
    parameter int p_data_bits    = 32,
    parameter int p_seq_num_bits = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    X__WIntf.recv                      X,
    output logic [4:0]                 rf_waddr,
    output logic [p_data_bits-1:0]     rf_wdata,
    output logic                       rf_wen,
    output logic                       commit_val,
    output logic [p_addr_bits-1:0]     commit_pc,
    output logic [p_seq_num_bits-1:0]  commit_seq_num,
    output logic [8*TRACE_CHARS-1:0]   line_trace
);
    localparam int DEPTH = rob_depth(p_seq_num_bits);

    logic [DEPTH-1:0]          valid;
    logic [p_seq_num_bits-1:0] head;
    logic                      accept, bypass, store, retire_buf;
    logic [p_addr_bits-1:0]    rd_pc;
    logic [4:0]                rd_waddr;
    logic [p_data_bits-1:0]    rd_wdata;
    logic                      rd_wen;

    // rdy looks only at pre-clear state, so the slot retiring this cycle is never re-filled.
    assign X.rdy  = !valid[X.seq_num];
    assign accept = X.val && !valid[X.seq_num];

`ifdef IN_ORDER_WRITEBACK_BYPASS_EN
    assign bypass = X.val && (X.seq_num == head) && !valid[head];
`else
    assign bypass = 1'b0;
`endif

    assign store      = accept && !bypass;
    assign retire_buf = valid[head];

    wb_rob_storage #(
        .p_addr_bits   (p_addr_bits),
        .p_data_bits   (p_data_bits),
        .p_seq_num_bits(p_seq_num_bits)
    ) u_storage (
        .clk     (clk),
        .wr_en   (store),
        .wr_idx  (X.seq_num),
        .wr_pc   (X.pc),
        .wr_waddr(X.waddr),
        .wr_wdata(X.wdata),
        .wr_wen  (X.wen),
        .rd_idx  (head),
        .rd_pc   (rd_pc),
        .rd_waddr(rd_waddr),
        .rd_wdata(rd_wdata),
        .rd_wen  (rd_wen)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        commit_val     = 1'b0;
        commit_pc      = '0;
        commit_seq_num = '0;
        rf_waddr       = '0;
        rf_wdata       = '0;
        rf_wen         = 1'b0;
        if (retire_buf) begin
            commit_val     = 1'b1;
            commit_pc      = rd_pc;
            commit_seq_num = head;
            rf_waddr       = rd_waddr;
            rf_wdata       = rd_wdata;
            rf_wen         = rd_wen && (rd_waddr != 5'd0);
        end else if (bypass) begin
            commit_val     = 1'b1;
            commit_pc      = X.pc;
            commit_seq_num = head;
            rf_waddr       = X.waddr;
            rf_wdata       = X.wdata;
            rf_wen         = X.wen && (X.waddr != 5'd0);
        end
    end

    // NOTE: state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
            head  <= '0;
        end else begin
            if (retire_buf) valid[head]      <= 1'b0;
            if (store)      valid[X.seq_num] <= 1'b1;
            if (commit_val) head             <= head + 1'b1;
        end
    end

    assign line_trace = {"H:", hex_byte(8'(head)),
                         " A:", accept ? hex_byte(8'(X.seq_num)) : TRACE_IDLE,
                         " R:", commit_val ? hex_byte(8'(commit_seq_num)) : TRACE_IDLE};
endmodule

// File: tb/tb_in_order_writeback.sv
// Self-checking bench for in_order_writeback: directed scenarios plus random
// out-of-order batches scored against a slot-array reference model.
module tb_in_order_writeback;
    import in_order_writeback_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = 3;
    localparam int DEPTH = 8;
`ifdef IN_ORDER_WRITEBACK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    X__WIntf #(.p_addr_bits(AW), .p_data_bits(DW), .p_seq_num_bits(SW)) x_if ();

    logic [4:0]               rf_waddr;
    logic [DW-1:0]            rf_wdata;
    logic                     rf_wen;
    logic                     commit_val;
    logic [AW-1:0]            commit_pc;
    logic [SW-1:0]            commit_seq_num;
    logic [8*TRACE_CHARS-1:0] line_trace;

    in_order_writeback #(.p_addr_bits(AW), .p_data_bits(DW), .p_seq_num_bits(SW)) dut (
        .clk           (clk),
        .rst           (rst),
        .X             (x_if),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rf_wen        (rf_wen),
        .commit_val    (commit_val),
        .commit_pc     (commit_pc),
        .commit_seq_num(commit_seq_num),
        .line_trace    (line_trace)
    );

    typedef struct packed {
        logic          rdy;
        logic          val;
        logic [SW-1:0] seq;
        logic [AW-1:0] pc;
        logic [4:0]    waddr;
        logic [DW-1:0] wdata;
        logic          wen;
    } obs_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [4:0]    waddr;
        logic [DW-1:0] wdata;
        logic          wen;
    } msg_t;

    // Reference model: which seq slots hold a finished instruction, and the next to retire.
    bit   m_valid [DEPTH];
    msg_t m_mem   [DEPTH];
    int   m_head;
    obs_t log_q [$];
    int   checks = 0;
    int   failures = 0;

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_head = 0;
        log_q.delete();
    endtask

    function automatic obs_t model_expect(output bit bypassed);
        obs_t e;
        msg_t m;
        bit   hit;
        e = '0;
        hit = 1'b0;
        bypassed = 1'b0;
        e.rdy = !m_valid[x_if.seq_num];
        if (m_valid[m_head]) begin
            m = m_mem[m_head];
            hit = 1'b1;
        end else if (BYPASS && x_if.val && int'(x_if.seq_num) == m_head) begin
            m = '{pc: x_if.pc, waddr: x_if.waddr, wdata: x_if.wdata, wen: x_if.wen};
            hit = 1'b1;
            bypassed = 1'b1;
        end
        if (hit) begin
            e.val   = 1'b1;
            e.seq   = SW'(m_head);
            e.pc    = m.pc;
            e.waddr = m.waddr;
            e.wdata = m.wdata;
            e.wen   = m.wen && (m.waddr != 5'd0);
        end
        return e;
    endfunction

    // One clock: compare all outputs at the falling edge, advance the model, return observation.
    task automatic tick(input string tag, output obs_t o);
        obs_t e;
        bit   byp;
        @(negedge clk);
        o = '{rdy: x_if.rdy, val: commit_val, seq: commit_seq_num, pc: commit_pc,
              waddr: rf_waddr, wdata: rf_wdata, wen: rf_wen};
        e = model_expect(byp);
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL %s outputs: got %h expected %h (rdy,val,seq,pc,waddr,wdata,wen)", tag, o, e);
        end
        if (o.val) log_q.push_back(o);
        if (x_if.val && e.rdy && !byp) begin
            m_valid[x_if.seq_num] = 1'b1;
            m_mem[x_if.seq_num] = '{pc: x_if.pc, waddr: x_if.waddr, wdata: x_if.wdata, wen: x_if.wen};
        end
        if (e.val) begin
            if (!byp) m_valid[m_head] = 1'b0;
            m_head = (m_head + 1) % DEPTH;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string tag, input int seq, input logic [4:0] wa,
                        input logic [DW-1:0] wd, input logic we);
        obs_t o;
        x_if.val     = 1'b1;
        x_if.seq_num = SW'(seq);
        x_if.pc      = $urandom;
        x_if.waddr   = wa;
        x_if.wdata   = wd;
        x_if.wen     = we;
        for (int n = 0; n < 60; n++) begin
            tick(tag, o);
            if (o.rdy) break;
            if (n == 59) begin
                checks++;
                failures++;
                $display("FAIL %s accept timeout: seq %0d never ready within 60 cycles", tag, seq);
            end
        end
        x_if.val = 1'b0;
    endtask

    task automatic idle(input string tag, input int n);
        obs_t o;
        x_if.val = 1'b0;
        for (int i = 0; i < n; i++) begin
            x_if.seq_num = SW'($urandom_range(0, DEPTH - 1));
            tick(tag, o);
        end
    endtask

    task automatic drain(input string tag);
        bit busy;
        for (int i = 0; i < 100; i++) begin
            busy = 1'b0;
            foreach (m_valid[k]) busy |= m_valid[k];
            if (!busy) return;
            idle(tag, 1);
        end
        checks++;
        failures++;
        $display("FAIL %s drain timeout: entries still buffered after 100 cycles", tag);
    endtask

    task automatic apply_reset();
        x_if.val = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8*TRACE_CHARS-1:0] t_exp;
        x_if.val = 1'b0; x_if.seq_num = '0; x_if.pc = '0;
        x_if.waddr = '0; x_if.wdata = '0; x_if.wen = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (commit_val !== 1'b0 || rf_wen !== 1'b0 || commit_seq_num !== '0 || rf_wdata !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got val=%b wen=%b seq=%0d wdata=%h required all 0",
                     commit_val, rf_wen, commit_seq_num, rf_wdata);
        end
        checks++;
        if (x_if.rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_rdy: got %b required 1", x_if.rdy);
        end
        t_exp = "H:00 A:-- R:--";
        checks++;
        if (line_trace !== t_exp) begin
            failures++;
            $display("FAIL reset_trace: got \"%s\" required \"%s\"", line_trace, t_exp);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        #1;
        x_if.val = 1'b1; x_if.seq_num = 3'd2;
        #1;
        t_exp = "H:00 A:02 R:--";
        checks++;
        if (line_trace !== t_exp) begin
            failures++;
            $display("FAIL accept_trace: got \"%s\" required \"%s\"", line_trace, t_exp);
        end
        x_if.val = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_in_order();
        apply_reset();
        send("in_order", 0, 5'd1, 32'd3, 1'b1);
        idle("in_order", 3);
        checks++;
        if (log_q.size() != 1) begin
            failures++;
            $display("FAIL in_order_count: got %0d commits required 1", log_q.size());
        end else begin
            checks++;
            if (log_q[0].seq !== 3'd0 || log_q[0].waddr !== 5'd1 || log_q[0].wdata !== 32'd3 || log_q[0].wen !== 1'b1) begin
                failures++;
                $display("FAIL in_order_commit: got seq=%0d waddr=%0d wdata=%0d wen=%b required 0/1/3/1",
                         log_q[0].seq, log_q[0].waddr, log_q[0].wdata, log_q[0].wen);
            end
        end
    endtask

    task automatic test_reorder();
        apply_reset();
        send("reorder", 2, 5'd4, 32'd30, 1'b1);
        send("reorder", 1, 5'd3, 32'd20, 1'b1);
        send("reorder", 0, 5'd2, 32'd10, 1'b1);
        idle("reorder", 4);
        checks++;
        if (log_q.size() != 3) begin
            failures++;
            $display("FAIL reorder_count: got %0d commits required 3", log_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (log_q[i].seq !== SW'(i) || log_q[i].wdata !== DW'(10 * (i + 1))) begin
                    failures++;
                    $display("FAIL reorder_commit%0d: got seq=%0d wdata=%0d required seq=%0d wdata=%0d",
                             i, log_q[i].seq, log_q[i].wdata, i, 10 * (i + 1));
                end
            end
        end
    endtask

    task automatic test_no_write();
        apply_reset();
        send("no_write", 0, 5'd0, 32'h55, 1'b1);
        send("no_write", 1, 5'd7, 32'h66, 1'b0);
        idle("no_write", 3);
        checks++;
        if (log_q.size() != 2 || log_q[0].wen !== 1'b0 || log_q[1].wen !== 1'b0) begin
            failures++;
            $display("FAIL no_write: got %0d commits (rf_wen must be 0 for both) required 2", log_q.size());
        end
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++)
            send("wrap", i % DEPTH, 5'($urandom_range(1, 31)), $urandom, 1'b1);
        idle("wrap", 3);
        checks++;
        if (log_q.size() != 16) begin
            failures++;
            $display("FAIL wrap_count: got %0d commits required 16", log_q.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (log_q[i].seq !== SW'(i % DEPTH)) begin
                    failures++;
                    $display("FAIL wrap_order%0d: got seq %0d required %0d", i, log_q[i].seq, i % DEPTH);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        int   zeros;
        apply_reset();
        send("backpressure", 1, 5'd9, 32'h111, 1'b1);
        x_if.val = 1'b1; x_if.seq_num = 3'd1; x_if.wdata = 32'h222;
        for (int i = 0; i < 3; i++) begin
            tick("backpressure", o);
            checks++;
            if (o.rdy !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_dup%0d: got rdy %b required 0", i, o.rdy);
            end
        end
        send("backpressure", 0, 5'd8, 32'h333, 1'b1);
        x_if.val = 1'b1; x_if.seq_num = 3'd1; x_if.wdata = 32'h444;
        zeros = 0;
        for (int i = 0; i < 10; i++) begin
            tick("backpressure", o);
            if (o.rdy) break;
            zeros++;
        end
        x_if.val = 1'b0;
        checks++;
        if (zeros != (BYPASS ? 1 : 2)) begin
            failures++;
            $display("FAIL backpressure_release: got %0d stalled cycles required %0d", zeros, BYPASS ? 1 : 2);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send("reset_mid", 3, 5'd3, 32'h3, 1'b1);
        send("reset_mid", 4, 5'd4, 32'h4, 1'b1);
        x_if.seq_num = 3'd3;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (commit_val !== 1'b0 || x_if.rdy !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid_hold%0d: got commit_val=%b rdy=%b required 0/1", i, commit_val, x_if.rdy);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        send("reset_mid", 0, 5'd5, 32'h77, 1'b1);
        idle("reset_mid", 3);
        checks++;
        if (log_q.size() != 1 || log_q[0].seq !== 3'd0 || log_q[0].wdata !== 32'h77) begin
            failures++;
            $display("FAIL reset_mid_first: got %0d commits, first seq %0d required 1 commit of seq 0",
                     log_q.size(), (log_q.size() > 0) ? int'(log_q[0].seq) : -1);
        end
    endtask

    task automatic test_random();
        int perm [DEPTH];
        int bad;
        apply_reset();
        for (int b = 0; b < 6; b++) begin
            foreach (perm[i]) perm[i] = i;
            for (int i = DEPTH - 1; i > 0; i--) begin
                int j, t;
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            foreach (perm[i]) begin
                send("random", perm[i], 5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
                if ($urandom_range(0, 3) == 0) idle("random", $urandom_range(1, 2));
            end
        end
        drain("random");
        bad = 0;
        foreach (log_q[i]) if (log_q[i].seq !== SW'(i % DEPTH)) bad++;
        checks++;
        if (log_q.size() != 6 * DEPTH || bad != 0) begin
            failures++;
            $display("FAIL random_order: got %0d commits with %0d out of order required %0d in order",
                     log_q.size(), bad, 6 * DEPTH);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_in_order();
        test_reorder();
        test_no_write();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
